// File: rtl/mips_pkg.sv
// Shared pipeline types for the MIPS memory stage: data widths, instruction/control
// bundles and the EX/MEM and MEM/WB pipeline records.
package mips_pkg;

  localparam int unsigned DATA         = 32;
  localparam int unsigned ADDRESSWIDTH = 32;
  localparam int unsigned REGW         = 5;

  typedef logic [DATA-1:0] Instruct;

  typedef struct packed {
    logic memRead;
    logic memWrite;
    logic memToReg;
    logic regWrite;
    logic halt;
  } Control;

  typedef struct packed {
    logic            valid;
    logic [DATA-1:0] alu_out;
    logic [DATA-1:0] write_data;
    Instruct         instr;
    Control          cntrl;
    logic [REGW-1:0] rd;
  } ex_mem_t;

  typedef struct packed {
    logic            valid;
    logic [DATA-1:0] alu_out;
    logic            mem_to_reg;
    logic            load_zero;
    logic            reg_write;
    logic [REGW-1:0] rd;
    Instruct         instr;
  } mem_wb_t;

  // Register r0 is hard-wired, so a write to it is never announced.
  function automatic logic writes_reg(input logic valid, input Control c,
                                      input logic [REGW-1:0] rd);
    return valid && c.regWrite && (rd != '0);
  endfunction

endpackage

// File: rtl/data_memory.sv
// Single-port data memory: synchronous read, write-first on a same-cycle write.
module data_memory #(
  parameter int unsigned WORDS = 1024,
  parameter int unsigned WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic                     we,
  input  logic [$clog2(WORDS)-1:0] addr,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [WORDS];

  // Contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
        rdata     <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/memory_stage.sv
// MIPS memory stage: EX/MEM and MEM/WB registers around the data memory, retire counter
// and halt logic. Define MEM_STAGE_BOUNDS_CHECK_EN to fault misaligned/out-of-range accesses.
module memory_stage
  import mips_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 1024
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            exValid,
  input  logic [DATA-1:0] aluOut,
  input  logic [DATA-1:0] writeData,
  input  Instruct         instr,
  input  Control          cntrl,
  input  logic [REGW-1:0] rd,
  output logic [DATA-1:0] memDataOut,
  output logic [REGW-1:0] memRd,
  output logic            memRegWrite,
  output logic [DATA-1:0] wbData,
  output logic [REGW-1:0] wbRd,
  output logic            wbRegWrite,
  output logic [31:0]     retired,
  output logic            halted,
  output logic            memFault
);

  localparam int unsigned AW = $clog2(MEM_WORDS);

  ex_mem_t                 ex_mem_q;
  mem_wb_t                 mem_wb_q;
  logic [ADDRESSWIDTH-1:0] addr;
  logic [AW-1:0]           index;
  logic                    mem_op;
  logic                    bad_addr;
  logic                    mem_en;
  logic                    mem_we;
  logic [DATA-1:0]         rdata;
  logic                    unused_c;

  assign addr   = ADDRESSWIDTH'(ex_mem_q.alu_out);
  assign index  = addr[AW+1:2];
  assign mem_op = ex_mem_q.valid && !halted &&
                  (ex_mem_q.cntrl.memRead || ex_mem_q.cntrl.memWrite);

`ifdef MEM_STAGE_BOUNDS_CHECK_EN
  localparam logic [ADDRESSWIDTH-1:0] LIMIT = ADDRESSWIDTH'(4 * MEM_WORDS);
  assign bad_addr = (addr[1:0] != 2'b00) || (addr >= LIMIT);
`else
  assign bad_addr = 1'b0;
`endif

  // Faulting accesses never touch the array.
  assign mem_en = mem_op && !bad_addr;
  assign mem_we = mem_en && ex_mem_q.cntrl.memWrite;

  data_memory #(
    .WORDS (MEM_WORDS),
    .WIDTH (DATA)
  ) u_data_memory (
    .clk   (clk),
    .en    (mem_en),
    .we    (mem_we),
    .addr  (index),
    .wdata (ex_mem_q.write_data),
    .rdata (rdata)
  );

  // Pipeline registers, retire count and sticky status; everything freezes once halted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_mem_q <= '0;
      mem_wb_q <= '0;
      retired  <= '0;
      halted   <= 1'b0;
      memFault <= 1'b0;
    end else if (!halted) begin
      ex_mem_q <= '{valid:      exValid,
                    alu_out:    aluOut,
                    write_data: writeData,
                    instr:      instr,
                    cntrl:      cntrl,
                    rd:         rd};
      mem_wb_q <= '{valid:      ex_mem_q.valid,
                    alu_out:    ex_mem_q.alu_out,
                    mem_to_reg: ex_mem_q.cntrl.memToReg,
                    load_zero:  mem_op && bad_addr,
                    reg_write:  writes_reg(ex_mem_q.valid, ex_mem_q.cntrl, ex_mem_q.rd),
                    rd:         ex_mem_q.rd,
                    instr:      ex_mem_q.instr};
      if (ex_mem_q.valid) begin
        retired <= retired + 32'd1;
      end
      if (ex_mem_q.valid && ex_mem_q.cntrl.halt) begin
        halted <= 1'b1;
      end
      if (mem_op && bad_addr) begin
        memFault <= 1'b1;
      end
    end
  end

  // The memory's read register acts as the MEM/WB load-data field.
  always_comb begin
    wbData = mem_wb_q.alu_out;
    if (mem_wb_q.mem_to_reg) begin
      wbData = mem_wb_q.load_zero ? '0 : rdata;
    end
  end

  assign memDataOut  = ex_mem_q.alu_out;
  assign memRd       = ex_mem_q.rd;
  assign memRegWrite = writes_reg(ex_mem_q.valid, ex_mem_q.cntrl, ex_mem_q.rd);
  assign wbRd        = mem_wb_q.rd;
  assign wbRegWrite  = mem_wb_q.reg_write;

  assign unused_c = ^{mem_wb_q.instr, addr, mem_wb_q.valid};

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: directed vector table, multi-cycle corner
// sequences and a randomized run against a history/array reference model.
module tb_memory_stage;
  import mips_pkg::*;

  localparam int unsigned MEM_WORDS = 1024;
`ifdef MEM_STAGE_BOUNDS_CHECK_EN
  localparam bit BOUNDS = 1'b1;
`else
  localparam bit BOUNDS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        exValid;
  logic [31:0] aluOut;
  logic [31:0] writeData;
  Instruct     instr;
  Control      cntrl;
  logic [4:0]  rd;
  logic [31:0] memDataOut;
  logic [4:0]  memRd;
  logic        memRegWrite;
  logic [31:0] wbData;
  logic [4:0]  wbRd;
  logic        wbRegWrite;
  logic [31:0] retired;
  logic        halted;
  logic        memFault;

  always #5 clk = ~clk;

  memory_stage #(.MEM_WORDS(MEM_WORDS)) dut (
    .clk(clk), .rst(rst), .exValid(exValid), .aluOut(aluOut), .writeData(writeData),
    .instr(instr), .cntrl(cntrl), .rd(rd), .memDataOut(memDataOut), .memRd(memRd),
    .memRegWrite(memRegWrite), .wbData(wbData), .wbRd(wbRd), .wbRegWrite(wbRegWrite),
    .retired(retired), .halted(halted), .memFault(memFault)
  );

  typedef struct {
    logic        valid;
    logic [31:0] alu;
    logic [31:0] wd;
    Control      c;
    logic [4:0]  rd;
  } op_t;

  typedef struct {
    op_t         op;
    logic [31:0] e_mem;
    logic [4:0]  e_mrd;
    logic        e_mrw;
    logic [31:0] e_wb;
    logic [4:0]  e_wrd;
    logic        e_wrw;
    logic [31:0] e_ret;
  } vec_t;

  typedef struct {
    op_t         op;
    logic [31:0] ld;
    logic        ld_known;
  } ent_t;

  int total = 0;
  int bad   = 0;

  // Reference model: every issued instruction in order, plus a sparse word array.
  ent_t        hist[$];
  logic [31:0] mmem [int unsigned];
  logic [31:0] m_ret;
  logic        m_halt;
  logic        m_fault;

  function automatic op_t mk(input logic v, input logic [31:0] a, input logic [31:0] w,
                             input logic mr, input logic mw, input logic m2r,
                             input logic rw, input logic h, input logic [4:0] r);
    op_t o;
    o.valid = v;
    o.alu   = a;
    o.wd    = w;
    o.c     = '{memRead: mr, memWrite: mw, memToReg: m2r, regWrite: rw, halt: h};
    o.rd    = r;
    return o;
  endfunction

  function automatic op_t idle();
    return mk(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
  endfunction

  function automatic logic faulty(input logic [31:0] a);
    return BOUNDS && ((a % 4) != 0 || a >= 32'(4 * MEM_WORDS));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    ent_t z;
    z.op = idle();
    z.ld = '0;
    z.ld_known = 1'b0;
    hist.delete();
    hist.push_back(z);
    hist.push_back(z);
    m_ret   = '0;
    m_halt  = 1'b0;
    m_fault = 1'b0;
  endtask

  // One clock edge: newest entry retires (memory effect applied) and op is issued.
  task automatic model_edge(input op_t op);
    ent_t e;
    ent_t n;
    int unsigned w;
    if (m_halt) return;
    e = hist[hist.size()-1];
    w = (e.op.alu / 4) % MEM_WORDS;
    if (e.op.valid) begin
      if ((e.op.c.memRead || e.op.c.memWrite) && faulty(e.op.alu)) begin
        m_fault = 1'b1;
        e.ld = '0;
        e.ld_known = 1'b1;
      end else if (e.op.c.memWrite) begin
        mmem[w] = e.op.wd;
      end else if (e.op.c.memRead) begin
        e.ld_known = mmem.exists(w);
        e.ld = e.ld_known ? mmem[w] : '0;
      end
      m_ret = m_ret + 32'd1;
      if (e.op.c.halt) m_halt = 1'b1;
    end
    hist[hist.size()-1] = e;
    n.op = op;
    n.ld = '0;
    n.ld_known = 1'b0;
    hist.push_back(n);
  endtask

  task automatic drive(input op_t op);
    exValid   = op.valid;
    aluOut    = op.alu;
    writeData = op.wd;
    cntrl     = op.c;
    rd        = op.rd;
    instr     = $urandom;
  endtask

  task automatic step(input op_t op);
    drive(op);
    @(posedge clk);
    model_edge(op);
    #1;
  endtask

  task automatic pulse_reset();
    drive(idle());
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_memDataOut"}, memDataOut, 32'h0);
    chk({tag, "_memRd"}, 32'(memRd), 32'h0);
    chk({tag, "_memRegWrite"}, 32'(memRegWrite), 32'h0);
    chk({tag, "_wbData"}, wbData, 32'h0);
    chk({tag, "_wbRd"}, 32'(wbRd), 32'h0);
    chk({tag, "_wbRegWrite"}, 32'(wbRegWrite), 32'h0);
    chk({tag, "_retired"}, retired, 32'h0);
    chk({tag, "_halted"}, 32'(halted), 32'h0);
    chk({tag, "_memFault"}, 32'(memFault), 32'h0);
  endtask

  task automatic check_model();
    ent_t s1;
    ent_t s2;
    s1 = hist[hist.size()-1];
    s2 = hist[hist.size()-2];
    chk("rnd_memDataOut", memDataOut, s1.op.alu);
    chk("rnd_memRd", 32'(memRd), 32'(s1.op.rd));
    chk("rnd_memRegWrite", 32'(memRegWrite),
        32'(s1.op.valid && s1.op.c.regWrite && s1.op.rd != 0));
    chk("rnd_wbRd", 32'(wbRd), 32'(s2.op.rd));
    chk("rnd_wbRegWrite", 32'(wbRegWrite),
        32'(s2.op.valid && s2.op.c.regWrite && s2.op.rd != 0));
    chk("rnd_retired", retired, m_ret);
    chk("rnd_halted", 32'(halted), 32'(m_halt));
    chk("rnd_memFault", 32'(memFault), 32'(m_fault));
    if (s2.op.valid && !s2.op.c.memToReg)
      chk("rnd_wbData_alu", wbData, s2.op.alu);
    else if (s2.op.valid && s2.ld_known)
      chk("rnd_wbData_load", wbData, s2.ld);
  endtask

  function automatic op_t rnd_op();
    op_t         o;
    int unsigned k = $urandom_range(0, 3);
    logic        v = ($urandom_range(0, 3) != 0);
    logic [31:0] a = 32'($urandom_range(0, 15)) << 2;
    logic [4:0]  r = 5'($urandom_range(0, 31));
    case (k)
      0:       o = mk(v, a, $urandom, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, r);
      1:       o = mk(v, a, $urandom, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, r);
      default: o = mk(v, $urandom, $urandom, 1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)),
                      1'b0, r);
    endcase
    return o;
  endfunction

  vec_t tbl [8];

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] exp_fault_wb;
    tbl[0] = '{mk(1, 32'h10, 32'hDEADBEEF, 0, 1, 0, 0, 0, 5'd0),
               32'h10, 5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'd0};
    tbl[1] = '{mk(1, 32'h10, 32'h0, 1, 0, 1, 1, 0, 5'd3),
               32'h10, 5'd3, 1'b1, 32'h10, 5'd0, 1'b0, 32'd1};
    tbl[2] = '{mk(1, 32'h55, 32'h0, 0, 0, 0, 1, 0, 5'd7),
               32'h55, 5'd7, 1'b1, 32'hDEADBEEF, 5'd3, 1'b1, 32'd2};
    tbl[3] = '{mk(1, 32'h99, 32'h0, 0, 0, 0, 1, 0, 5'd0),
               32'h99, 5'd0, 1'b0, 32'h55, 5'd7, 1'b1, 32'd3};
    tbl[4] = '{idle(), 32'h0, 5'd0, 1'b0, 32'h99, 5'd0, 1'b0, 32'd4};
    tbl[5] = '{idle(), 32'h0, 5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'd4};
    tbl[6] = '{mk(0, 32'h77, 32'h0, 0, 0, 0, 1, 0, 5'd5),
               32'h77, 5'd5, 1'b0, 32'h0, 5'd0, 1'b0, 32'd4};
    tbl[7] = '{idle(), 32'h0, 5'd0, 1'b0, 32'h77, 5'd5, 1'b0, 32'd4};

    rst = 1'b1;
    drive(idle());
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_zero("por");
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      step(tbl[i].op);
      chk($sformatf("v%0d_memDataOut", i), memDataOut, tbl[i].e_mem);
      chk($sformatf("v%0d_memRd", i), 32'(memRd), 32'(tbl[i].e_mrd));
      chk($sformatf("v%0d_memRegWrite", i), 32'(memRegWrite), 32'(tbl[i].e_mrw));
      chk($sformatf("v%0d_wbData", i), wbData, tbl[i].e_wb);
      chk($sformatf("v%0d_wbRd", i), 32'(wbRd), 32'(tbl[i].e_wrd));
      chk($sformatf("v%0d_wbRegWrite", i), 32'(wbRegWrite), 32'(tbl[i].e_wrw));
      chk($sformatf("v%0d_retired", i), retired, tbl[i].e_ret);
    end

    // Reset between edges while a store sits in EX/MEM.
    step(mk(1, 32'h40, 32'h11111111, 0, 1, 0, 0, 0, 5'd9));
    step(mk(0, 32'h66, 32'h0, 0, 0, 0, 1, 0, 5'd6));
    step(mk(1, 32'h40, 32'hCAFEF00D, 0, 1, 0, 0, 0, 5'd9));
    chk("mid_pre_memDataOut", memDataOut, 32'h40);
    drive(idle());
    #1;
    rst = 1'b1;
    #1;
    check_zero("mid_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    step(mk(1, 32'h40, 32'h0, 1, 0, 1, 1, 0, 5'd2));
    step(idle());
    chk("mid_load_wbData", wbData, 32'h11111111);
    chk("mid_load_wbRd", 32'(wbRd), 32'd2);
    chk("mid_load_wbRegWrite", 32'(wbRegWrite), 32'd1);
    chk("mid_load_retired", retired, 32'd1);

    // Halt followed by a store that must be suppressed.
    pulse_reset();
    step(mk(1, 32'h20, 32'hA5A5A5A5, 0, 1, 0, 0, 0, 5'd0));
    step(mk(1, 32'h44, 32'h0, 0, 0, 0, 0, 1, 5'd0));
    chk("halt_early", 32'(halted), 32'd0);
    step(mk(1, 32'h20, 32'h00000BAD, 0, 1, 0, 0, 0, 5'd0));
    chk("halt_set", 32'(halted), 32'd1);
    chk("halt_retired", retired, 32'd2);
    chk("halt_wbData", wbData, 32'h44);
    step(mk(1, 32'h99, 32'h0, 0, 0, 0, 1, 0, 5'd1));
    step(mk(1, 32'h99, 32'h0, 0, 0, 0, 1, 0, 5'd1));
    chk("halt_sticky", 32'(halted), 32'd1);
    chk("halt_retired_frozen", retired, 32'd2);
    chk("halt_mem_frozen", memDataOut, 32'h20);
    chk("halt_wb_frozen", wbData, 32'h44);
    pulse_reset();
    chk("halt_cleared", 32'(halted), 32'd0);
    step(mk(1, 32'h20, 32'h0, 1, 0, 1, 1, 0, 5'd2));
    step(idle());
    chk("halt_readback", wbData, 32'hA5A5A5A5);

    // Misaligned store to 0x13 against word 4.
    pulse_reset();
    step(mk(1, 32'h10, 32'h0BADF00D, 0, 1, 0, 0, 0, 5'd0));
    step(mk(1, 32'h13, 32'h13131313, 0, 1, 0, 0, 0, 5'd0));
    step(mk(1, 32'h10, 32'h0, 1, 0, 1, 1, 0, 5'd4));
    step(idle());
    exp_fault_wb = BOUNDS ? 32'h0BADF00D : 32'h13131313;
    chk("bounds_word4", wbData, exp_fault_wb);
    chk("bounds_memFault", 32'(memFault), 32'(BOUNDS));

    // Randomized traffic against the reference model.
    pulse_reset();
    for (int i = 0; i < 400; i++) begin
      step(rnd_op());
      check_model();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
